// File: rtl/ctrl_pkg.sv
// Shared controller constants: RAM geometry for the upsampler datapath.
package ctrl;
    parameter int DATA_RAM_ADDRESS_WIDTH = 8;
endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer bus: sample handshake, instruction fetch path and MAC datapath strobes.
// master = sequencer side, slave = sample source / memories / datapath side.
interface ctrl_seq_if #(
    parameter int IAWIDTH = 6,
    parameter int DAWIDTH = ctrl::DATA_RAM_ADDRESS_WIDTH
);
    logic               sample_valid;
    logic               sample_ready;
    logic [IAWIDTH-1:0] imem_addr;
    logic               fetch;
    logic               lstg_f;
    logic               upse_f;
    logic [DAWIDTH-1:0] data_lptr;
    logic [DAWIDTH-1:0] data_uptr;
    logic [DAWIDTH-1:0] coef_ptr;
    logic [DAWIDTH-1:0] data_addr;
    logic [DAWIDTH-1:0] coef_addr;
    logic               acc_clr;
    logic               mac_en;
    logic               store_en;
    logic               out_valid;
    logic               done;
    logic               prog_err;

    modport master (
        input  sample_valid, lstg_f, upse_f, data_lptr, data_uptr, coef_ptr,
        output sample_ready, imem_addr, fetch, data_addr, coef_addr,
               acc_clr, mac_en, store_en, out_valid, done, prog_err
    );

    modport slave (
        output sample_valid, lstg_f, upse_f, data_lptr, data_uptr, coef_ptr,
        input  sample_ready, imem_addr, fetch, data_addr, coef_addr,
               acc_clr, mac_en, store_en, out_valid, done, prog_err
    );
endinterface

// File: rtl/ctrl_seq.sv
// Upsampler program sequencer: 4 cycles from sample accept to first mac_en, taps+4 per vector.
// Backpressure: sample_ready only in IDLE; the producer holds sample_valid until accepted.
module ctrl_seq #(
    parameter int IAWIDTH = 6,
    parameter int DAWIDTH = ctrl::DATA_RAM_ADDRESS_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, IREQ, FETCH, LOAD, MAC, STORE, DONE} state_t;

    localparam logic [IAWIDTH-1:0] PC_LAST = '1;

    state_t             state;
    logic [IAWIDTH-1:0] pc;
    logic [DAWIDTH-1:0] data_addr;
    logic [DAWIDTH-1:0] coef_addr;
    logic               sample_ready;
    logic               fetch;
    logic               acc_clr;
    logic               mac_en;
    logic               store_en;
    logic               out_valid;
    logic               done;
    logic               prog_err;

    // Strobes are set on the transition into the state they belong to, so each
    // one is a flop output that is high exactly while that state is current.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= '0;
            data_addr    <= '0;
            coef_addr    <= '0;
            sample_ready <= 1'b0;
            fetch        <= 1'b0;
            acc_clr      <= 1'b0;
            mac_en       <= 1'b0;
            store_en     <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            prog_err     <= 1'b0;
        end else begin
            fetch     <= 1'b0;
            acc_clr   <= 1'b0;
            mac_en    <= 1'b0;
            store_en  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_valid && sample_ready) begin
                        state        <= IREQ;
                        pc           <= '0;
                        prog_err     <= 1'b0;
                        sample_ready <= 1'b0;
                    end else begin
                        sample_ready <= 1'b1;
                    end
                end
                IREQ: begin
                    state <= FETCH;
                    fetch <= 1'b1;
                end
                FETCH: begin
                    state   <= LOAD;
                    acc_clr <= 1'b1;
                end
                LOAD: begin
                    data_addr <= bus.data_lptr;
                    coef_addr <= bus.coef_ptr;
                    mac_en    <= 1'b1;
                    state     <= MAC;
                end
                MAC: begin
                    if (data_addr == bus.data_uptr) begin
                        state     <= STORE;
                        store_en  <= 1'b1;
                        out_valid <= bus.upse_f;
                    end else begin
                        // natural wrap of the adders gives the ring segment when lptr > uptr
                        data_addr <= data_addr + 1'b1;
                        coef_addr <= coef_addr + 1'b1;
                        mac_en    <= 1'b1;
                    end
                end
                STORE: begin
                    if (bus.lstg_f) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (pc == PC_LAST) begin
                        prog_err <= 1'b1;
                        state    <= DONE;
                        done     <= 1'b1;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= IREQ;
                    end
                end
                DONE: begin
                    pc           <= '0;
                    state        <= IDLE;
                    sample_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_ready = sample_ready;
    assign bus.imem_addr    = pc;
    assign bus.fetch        = fetch;
    assign bus.data_addr    = data_addr;
    assign bus.coef_addr    = coef_addr;
    assign bus.acc_clr      = acc_clr;
    assign bus.mac_en       = mac_en;
    assign bus.store_en     = store_en;
    assign bus.out_valid    = out_valid;
    assign bus.done         = done;
    assign bus.prog_err     = prog_err;
endmodule
